// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - four-digit seven-segment scan controller with per-slot blanking
// Display values are double-buffered and swapped only at frame boundaries.
module digit_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [1:0]  sel,
    output logic        en_n,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [15:0]   disp;
    logic [15:0]   pend;
    logic [3:0]    dpd;
    logic [3:0]    pdp;
    logic          pvalid;
    logic          wrap;
    logic          boundary;
    logic [3:0]    nib;

    assign wrap     = (cnt == LAST);
    assign boundary = wrap && (sel == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sel    <= 2'd0;
            disp   <= 16'h0000;
            dpd    <= 4'h0;
            pend   <= 16'h0000;
            pdp    <= 4'h0;
            pvalid <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                sel <= sel + 2'd1;
            // A load landing on the boundary bypasses the pending buffer entirely.
            if (boundary) begin
                pvalid <= 1'b0;
                if (load) begin
                    disp <= value;
                    dpd  <= dp_in;
                end else if (pvalid) begin
                    disp <= pend;
                    dpd  <= pdp;
                end
            end else if (load) begin
                pend   <= value;
                pdp    <= dp_in;
                pvalid <= 1'b1;
            end
        end
    end

    generate
        if (BLANK == 0) begin : g_noblank
            assign en_n = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
            assign en_n = (cnt < BLANK_C);
        end
    endgenerate

    assign nib        = disp[{sel, 2'b00} +: 4];
    assign dp_n       = ~dpd[sel];
    assign frame_done = boundary;

    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - self-checking bench for digit_scan_ctrl (blanked and unblanked)
module tb_digit_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;

    logic [1:0] sel_a, sel_b;
    logic       en_n_a, en_n_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_n_a, dp_n_b;
    logic       fd_a, fd_b;

    int checks = 0;
    int errors = 0;

    // Reference model: absolute cycle count since reset, shown value, pending loads.
    int          t;
    logic [15:0] shown;
    logic [3:0]  shown_dp;
    logic [19:0] pq[$];
    logic [6:0]  seg_tab[16];

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut_a (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .sel(sel_a), .en_n(en_n_a), .seg(seg_a), .dp_n(dp_n_a), .frame_done(fd_a)
    );

    digit_scan_ctrl #(.DIV(DIV), .BLANK(0)) dut_b (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .sel(sel_b), .en_n(en_n_b), .seg(seg_b), .dp_n(dp_n_b), .frame_done(fd_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic check_all();
        int         s;
        logic [3:0] n;
        s = (t / DIV) % 4;
        n = shown[4*s +: 4];
        check("sel_a",  {30'd0, sel_a},  s);
        check("en_n_a", {31'd0, en_n_a}, ((t % DIV) < BLANK) ? 1 : 0);
        check("seg_a",  {25'd0, seg_a},  {25'd0, seg_tab[n]});
        check("dp_n_a", {31'd0, dp_n_a}, {31'd0, ~shown_dp[s]});
        check("fd_a",   {31'd0, fd_a},   ((t % FRAME) == FRAME - 1) ? 1 : 0);
        check("sel_b",  {30'd0, sel_b},  s);
        check("en_n_b", {31'd0, en_n_b}, 0);
        check("seg_b",  {25'd0, seg_b},  {25'd0, seg_tab[n]});
        check("dp_n_b", {31'd0, dp_n_b}, {31'd0, ~shown_dp[s]});
        check("fd_b",   {31'd0, fd_b},   ((t % FRAME) == FRAME - 1) ? 1 : 0);
    endtask

    task automatic step(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        check_all();
        rst   = r;
        load  = l;
        value = v;
        dp_in = d;
        if (r) begin
            t        = 0;
            shown    = 16'h0000;
            shown_dp = 4'h0;
            pq.delete();
        end else begin
            if ((t % FRAME) == FRAME - 1) begin
                if (l) begin
                    shown    = v;
                    shown_dp = d;
                end else if (pq.size() > 0) begin
                    {shown_dp, shown} = pq[$];
                end
                pq.delete();
            end else if (l) begin
                pq.push_back({d, v});
            end
            t++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic run_to_phase(input int ph);
        while ((t % FRAME) != ph) step(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0;
        repeat (2) @(posedge clk);
        t = 0; shown = 16'h0; shown_dp = 4'h0; pq.delete();

        // Free run after reset: two full frames of zeros.
        idle(2 * FRAME + 3);

        // Mid-frame load, visible from the next frame.
        run_to_phase(10);
        step(1'b0, 1'b1, 16'h1A2F, 4'b0100);
        idle(2 * FRAME);

        // Two loads in one frame; the last wins.
        run_to_phase(4);
        step(1'b0, 1'b1, 16'h1111, 4'b0001);
        idle(5);
        step(1'b0, 1'b1, 16'h2222, 4'b1000);
        idle(FRAME + 4);

        // Pending load overridden by a load on the boundary cycle.
        run_to_phase(12);
        step(1'b0, 1'b1, 16'h3333, 4'b1111);
        run_to_phase(FRAME - 1);
        step(1'b0, 1'b1, 16'h4444, 4'b0010);
        idle(2 * FRAME);

        // Reset at cnt=5, sel=2 with a load pending.
        run_to_phase(3);
        step(1'b0, 1'b1, 16'h9876, 4'b1111);
        run_to_phase(2 * DIV + 5);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        idle(2 * FRAME);

        // Randomized traffic including boundary loads and sporadic resets.
        for (int i = 0; i < 900; i++) begin
            logic r, l;
            r = ($urandom_range(0, 199) == 0);
            l = ($urandom_range(0, 6) == 0) || ((t % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1);
            step(r, l, 16'($urandom), 4'($urandom));
        end
        idle(FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
